// File: rtl/defuse_sequence_checker_pkg.sv
// -----------------------------------------------------------------------------
// defuse_pkg
// Shared definitions for the defuse sequence checker:
//   state_e          - game state of the sequence checker FSM
//   SEQ_LEN          - number of entries in the secret defuse sequence
//   MAX_STRIKES_DEF  - default number of wrong events that cause detonation
//   IDX_W            - width of a switch index
//   DEFUSE_SEQ       - secret order of switch indices; entry 0 is first
//   seq_at()         - lookup of the switch index expected at a given step
// -----------------------------------------------------------------------------
package defuse_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_DEFUSED   = 2'd2,
    ST_DETONATED = 2'd3
  } state_e;

  localparam int SEQ_LEN         = 4;
  localparam int MAX_STRIKES_DEF = 3;
  localparam int IDX_W           = 4;

  // Entry [0] is the first switch to raise: 3, 0, 2, 1.
  localparam logic [SEQ_LEN-1:0][IDX_W-1:0] DEFUSE_SEQ = {4'd1, 4'd2, 4'd0, 4'd3};

  // Returns the switch index expected at step position pos; out-of-range
  // positions return 0 and are never consulted while armed.
  function automatic logic [IDX_W-1:0] seq_at(input logic [2:0] pos);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < SEQ_LEN; i++) begin
      if (pos == 3'(i)) begin
        idx = DEFUSE_SEQ[i];
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/defuse_sequence_checker_if.sv
// -----------------------------------------------------------------------------
// defuse_sequence_checker_if
// Signal bundle between game control / board and the sequence checker.
//   switches_raw  raw switch levels          (master -> slave)
//   arm           start pulse                (master -> slave)
//   time_expired  countdown reached zero     (master -> slave)
//   sw_stable     debounced switch levels    (slave -> master)
//   step          correct entries so far     (slave -> master)
//   strikes       wrong-event count          (slave -> master)
//   wrong_pulse   one cycle per wrong event  (slave -> master)
//   defused       sequence completed         (slave -> master)
//   detonate      strikes exhausted / timeout(slave -> master)
// The checker uses the slave modport; the driver side uses master.
// -----------------------------------------------------------------------------
interface defuse_sequence_checker_if #(
  parameter int NUM_SW = 15
);
  logic [NUM_SW-1:0] switches_raw;
  logic              arm;
  logic              time_expired;
  logic [NUM_SW-1:0] sw_stable;
  logic [2:0]        step;
  logic [1:0]        strikes;
  logic              wrong_pulse;
  logic              defused;
  logic              detonate;

  modport master (
    output switches_raw, arm, time_expired,
    input  sw_stable, step, strikes, wrong_pulse, defused, detonate
  );

  modport slave (
    input  switches_raw, arm, time_expired,
    output sw_stable, step, strikes, wrong_pulse, defused, detonate
  );
endinterface

// File: rtl/defuse_sequence_checker_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
// One-bit synchroniser plus stability counter.
//   clock_100Mhz  system clock
//   reset         asynchronous, active-high
//   raw_i         raw, unsynchronised switch level
//   stable_o      debounced level (registered)
// A change is accepted once the synchronised level has differed from the
// stable level for DEBOUNCE_CYCLES consecutive cycles.
// -----------------------------------------------------------------------------
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clock_100Mhz,
  input  logic reset,
  input  logic raw_i,
  output logic stable_o
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter and stable-level next state. Comparing against DEBOUNCE_CYCLES-1
  // means the acceptance happens on the edge where the count would reach
  // DEBOUNCE_CYCLES, giving DEBOUNCE_CYCLES+2 cycles raw-to-stable latency.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Synchroniser, counter and stable-level registers.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o = stable_q;
endmodule

// File: rtl/defuse_sequence_checker.sv
// -----------------------------------------------------------------------------
// defuse_sequence_checker
// Debounces the board switches and checks they are raised in the secret
// order. Reports strikes, a wrong-event pulse and a terminal defused or
// detonated result.
//   clock_100Mhz  system clock (100 MHz)
//   reset         asynchronous, active-high
//   bus           defuse_sequence_checker_if.slave (see interface header)
// Configuration macro: DEFUSE_STRIKES_EN. When defined, MAX_STRIKES wrong
// events detonate; when undefined, the first wrong event detonates and
// strikes stays 0.
// -----------------------------------------------------------------------------
module defuse_sequence_checker
  import defuse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int NUM_SW          = 15,
  parameter int SEQ_LEN         = defuse_pkg::SEQ_LEN,
  parameter int MAX_STRIKES     = defuse_pkg::MAX_STRIKES_DEF
) (
  input  logic                      clock_100Mhz,
  input  logic                      reset,
  defuse_sequence_checker_if.slave  bus
);
`ifdef DEFUSE_STRIKES_EN
  localparam bit STRIKES_EN = 1'b1;
`else
  localparam bit STRIKES_EN = 1'b0;
`endif
  // Number of wrong events that end the game.
  localparam int STRIKE_LIMIT = STRIKES_EN ? MAX_STRIKES : 1;

  logic [NUM_SW-1:0] sw_stable_s;
  logic [NUM_SW-1:0] prev_q;
  logic [NUM_SW-1:0] rise_s;
  logic              rise_any_s, rise_multi_s;
  logic [IDX_W-1:0]  rise_idx_s;
  logic              evt_valid_q, evt_multi_q;
  logic [IDX_W-1:0]  evt_idx_q;

  state_e            state_q, state_d;
  logic [2:0]        step_q, step_d;
  logic [1:0]        strikes_q, strikes_d;
  logic [2:0]        strikes_inc_s;
  logic              wrong_q, wrong_d;
  logic              defused_q, detonate_q;
  logic              correct_s;

  for (genvar g = 0; g < NUM_SW; g++) begin : g_deb
    switch_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clock_100Mhz (clock_100Mhz),
      .reset        (reset),
      .raw_i        (bus.switches_raw[g]),
      .stable_o     (sw_stable_s[g])
    );
  end

  // Rising-edge classification: none, exactly one (with its index), or several.
  always_comb begin
    rise_s       = sw_stable_s & ~prev_q;
    rise_any_s   = 1'b0;
    rise_multi_s = 1'b0;
    rise_idx_s   = '0;
    for (int i = 0; i < NUM_SW; i++) begin
      if (rise_s[i]) begin
        rise_multi_s = rise_multi_s | rise_any_s;
        rise_any_s   = 1'b1;
        rise_idx_s   = IDX_W'(i);
      end else begin
        rise_any_s   = rise_any_s;
      end
    end
  end

  // Previous-value and registered event, so the FSM sees a clean event one
  // cycle after sw_stable changes.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      prev_q      <= '0;
      evt_valid_q <= 1'b0;
      evt_multi_q <= 1'b0;
      evt_idx_q   <= '0;
    end else begin
      prev_q      <= sw_stable_s;
      evt_valid_q <= rise_any_s;
      evt_multi_q <= rise_multi_s;
      evt_idx_q   <= rise_idx_s;
    end
  end

  assign correct_s     = evt_valid_q & ~evt_multi_q & (evt_idx_q == seq_at(step_q));
  assign strikes_inc_s = {1'b0, strikes_q} + 3'd1;

  // Game FSM next state; time_expired outranks any event in the same cycle.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    strikes_d = strikes_q;
    wrong_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.arm) begin
          state_d   = ST_ARMED;
          step_d    = 3'd0;
          strikes_d = 2'd0;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_ARMED: begin
        if (bus.time_expired) begin
          state_d = ST_DETONATED;
        end else if (correct_s) begin
          step_d = step_q + 3'd1;
          if (step_q == 3'(SEQ_LEN - 1)) begin
            state_d = ST_DEFUSED;
          end else begin
            state_d = ST_ARMED;
          end
        end else if (evt_valid_q) begin
          wrong_d   = 1'b1;
          step_d    = 3'd0;
          strikes_d = STRIKES_EN ? strikes_inc_s[1:0] : 2'd0;
          if (strikes_inc_s >= 3'(STRIKE_LIMIT)) begin
            state_d = ST_DETONATED;
          end else begin
            state_d = ST_ARMED;
          end
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_DEFUSED:   state_d = ST_DEFUSED;
      ST_DETONATED: state_d = ST_DETONATED;
      default:      state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      step_q     <= 3'd0;
      strikes_q  <= 2'd0;
      wrong_q    <= 1'b0;
      defused_q  <= 1'b0;
      detonate_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      strikes_q  <= strikes_d;
      wrong_q    <= wrong_d;
      defused_q  <= (state_d == ST_DEFUSED);
      detonate_q <= (state_d == ST_DETONATED);
    end
  end

  assign bus.sw_stable   = sw_stable_s;
  assign bus.step        = step_q;
  assign bus.strikes     = strikes_q;
  assign bus.wrong_pulse = wrong_q;
  assign bus.defused     = defused_q;
  assign bus.detonate    = detonate_q;
endmodule

// File: tb/tb_defuse_sequence_checker.sv
// -----------------------------------------------------------------------------
// tb_defuse_sequence_checker
// Directed scenarios plus a randomised phase, checked against an
// event-level reference model of the defuse game rules.
// -----------------------------------------------------------------------------
module tb_defuse_sequence_checker;
  localparam int NSW = 15;
  localparam int DB  = 4;
`ifdef DEFUSE_STRIKES_EN
  localparam bit STRIKES_ON = 1'b1;
`else
  localparam bit STRIKES_ON = 1'b0;
`endif

  logic clock_100Mhz = 1'b0;
  logic reset        = 1'b1;

  defuse_sequence_checker_if #(.NUM_SW(NSW)) bus ();

  defuse_sequence_checker #(
    .DEBOUNCE_CYCLES (DB),
    .NUM_SW          (NSW),
    .SEQ_LEN         (4),
    .MAX_STRIKES     (3)
  ) dut (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .bus          (bus)
  );

  always #5 clock_100Mhz = ~clock_100Mhz;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: game rules at event granularity.
  int secret [4] = '{3, 0, 2, 1};
  bit m_armed, m_defused, m_detonated;
  int m_step, m_strikes;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input bit wp);
    check({tag, ".step"},        32'(bus.step),        32'(m_step));
    check({tag, ".strikes"},     32'(bus.strikes),     32'(m_strikes));
    check({tag, ".wrong_pulse"}, 32'(bus.wrong_pulse), 32'(wp));
    check({tag, ".defused"},     32'(bus.defused),     32'(m_defused));
    check({tag, ".detonate"},    32'(bus.detonate),    32'(m_detonated));
  endtask

  task automatic model_reset();
    m_armed = 0; m_defused = 0; m_detonated = 0; m_step = 0; m_strikes = 0;
  endtask

  task automatic model_arm();
    if (!m_armed && !m_defused && !m_detonated) begin
      m_armed = 1; m_step = 0; m_strikes = 0;
    end
  endtask

  task automatic model_event(input logic [NSW-1:0] mask, input bit te, output bit wrong);
    wrong = 0;
    if (!m_armed) return;
    if (te) begin
      m_armed = 0; m_detonated = 1;
      return;
    end
    if ($countones(mask) == 1 && mask[secret[m_step]]) begin
      m_step++;
      if (m_step == 4) begin m_armed = 0; m_defused = 1; end
    end else begin
      wrong  = 1;
      m_step = 0;
      if (STRIKES_ON) begin
        m_strikes++;
        if (m_strikes == 3) begin m_armed = 0; m_detonated = 1; end
      end else begin
        m_armed = 0; m_detonated = 1;
      end
    end
  endtask

  task automatic do_reset(input string tag);
    @(posedge clock_100Mhz); #1;
    #2 reset = 1'b1;
    #2;
    model_reset();
    check_outputs({tag, ".async"}, 1'b0);
    check({tag, ".sw_stable"}, 32'(bus.sw_stable), 32'd0);
    @(posedge clock_100Mhz); #1;
    reset = 1'b0;
  endtask

  task automatic do_arm(input string tag);
    @(posedge clock_100Mhz); #1;
    bus.arm = 1'b1;
    @(posedge clock_100Mhz); #1;
    bus.arm = 1'b0;
    model_arm();
    check_outputs(tag, 1'b0);
  endtask

  // Raise the switches in mask together, check debounce latency and the
  // two-cycle event-to-output timing, optionally with time_expired landing
  // in the same cycle as the event, then release.
  task automatic press(input logic [NSW-1:0] mask, input bit te, input string tag);
    int lat;
    bit hit, wexp;
    @(posedge clock_100Mhz); #1;
    bus.switches_raw = bus.switches_raw | mask;
    lat = 0; hit = 0;
    for (int k = 1; k <= 20 && !hit; k++) begin
      @(posedge clock_100Mhz); #1;
      if ((bus.sw_stable & mask) == mask) begin hit = 1; lat = k; end
    end
    check({tag, ".latency"}, 32'(lat), 32'(DB + 2));
    if (hit) begin
      @(posedge clock_100Mhz); #1;
      check_outputs({tag, ".pre"}, 1'b0);
      if (te) bus.time_expired = 1'b1;
      @(posedge clock_100Mhz); #1;
      bus.time_expired = 1'b0;
      model_event(mask, te, wexp);
      check_outputs(tag, wexp);
      @(posedge clock_100Mhz); #1;
      check({tag, ".pulse_end"}, 32'(bus.wrong_pulse), 32'd0);
    end
    repeat ($urandom_range(2, 6)) @(posedge clock_100Mhz);
    #1;
    bus.switches_raw = bus.switches_raw & ~mask;
    hit = 0;
    for (int k = 1; k <= 20 && !hit; k++) begin
      @(posedge clock_100Mhz); #1;
      if ((bus.sw_stable & mask) == '0) hit = 1;
    end
    check({tag, ".release"}, 32'(hit), 32'd1);
    repeat ($urandom_range(1, 4)) @(posedge clock_100Mhz);
  endtask

  function automatic logic [NSW-1:0] one(input int idx);
    logic [NSW-1:0] m;
    m = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    int a, b, r;
    logic [NSW-1:0] mask;
    bus.switches_raw = '0;
    bus.arm          = 1'b0;
    bus.time_expired = 1'b0;
    model_reset();
    repeat (3) @(posedge clock_100Mhz);
    #1;
    check_outputs("reset", 1'b0);
    check("reset.sw_stable", 32'(bus.sw_stable), 32'd0);
    reset = 1'b0;

    // Glitch of 3 cycles must not reach sw_stable.
    @(posedge clock_100Mhz); #1;
    bus.switches_raw[0] = 1'b1;
    repeat (3) @(posedge clock_100Mhz);
    #1;
    bus.switches_raw[0] = 1'b0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clock_100Mhz); #1;
      if (bus.sw_stable[0]) seen = 1;
    end
    check("glitch", 32'(seen), 32'd0);

    // Held switch is accepted after 6 cycles; events in IDLE are ignored.
    press(one(0), 1'b0, "idle_sw0");
    press(one(5), 1'b0, "idle_sw5");

    // Correct defuse.
    do_arm("arm1");
    for (int i = 0; i < 4; i++) press(one(secret[i]), 1'b0, "defuse");
    press(one(7), 1'b0, "after_defuse");

    // Strikes: three wrong switches, then the correct sequence is ignored.
    do_reset("rst2");
    do_arm("arm2");
    press(one(5), 1'b0, "strike1");
    press(one(7), 1'b0, "strike2");
    press(one(9), 1'b0, "strike3");
    for (int i = 0; i < 4; i++) press(one(secret[i]), 1'b0, "after_det");

    // Mid-sequence error then a full correct sequence.
    do_reset("rst3");
    do_arm("arm3");
    press(one(3), 1'b0, "mid_a");
    press(one(0), 1'b0, "mid_b");
    press(one(6), 1'b0, "mid_wrong");
    for (int i = 0; i < 4; i++) press(one(secret[i]), 1'b0, "mid_retry");

    // time_expired together with the final correct event: detonate wins.
    do_reset("rst4");
    do_arm("arm4");
    for (int i = 0; i < 3; i++) press(one(secret[i]), 1'b0, "race");
    press(one(secret[3]), 1'b1, "race_final");

    // Two switches rising together form one wrong event.
    do_reset("rst5");
    do_arm("arm5");
    a = $urandom_range(4, 14);
    b = (a == 14) ? 4 : a + 1;
    press(one(a) | one(b), 1'b0, "dual");

    // Reset mid-ARMED returns to IDLE; events ignored until arm.
    do_reset("rst6");
    do_arm("arm6");
    press(one(3), 1'b0, "pre_rst");
    do_reset("rst_mid");
    press(one(3), 1'b0, "idle_after_rst");
    press(one(8), 1'b0, "idle_after_rst_w");
    do_arm("arm7");

    // Randomised play checked against the model.
    for (int n = 0; n < 16; n++) begin
      if (m_defused || m_detonated) begin
        do_reset("rnd_rst");
        do_arm("rnd_arm");
      end
      r = $urandom_range(0, 9);
      if (r < 6) begin
        mask = one(secret[m_step]);
      end else if (r < 9) begin
        mask = one($urandom_range(0, 14));
      end else begin
        a = $urandom_range(0, 13);
        mask = one(a) | one(a + 1);
      end
      press(mask, ($urandom_range(0, 11) == 0), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
